// File: rtl/universal_shift_register8.sv
// universal_shift_register8: 8-bit register with hold, shift-left, shift-right
// and parallel-load modes. On shifts, serialin fills the vacated end. q is
// driven straight from the flops. reset is synchronous and takes priority
// over every mode.
module universal_shift_register8 (
  input  logic [8:1] inp,
  input  logic       serialin,
  input  logic       clk,
  input  logic       reset,
  output logic [8:1] q,
  input  logic [2:1] select
);

  localparam logic [2:1] SEL_HOLD  = 2'b00;
  localparam logic [2:1] SEL_LEFT  = 2'b01;
  localparam logic [2:1] SEL_RIGHT = 2'b10;
  localparam logic [2:1] SEL_LOAD  = 2'b11;

  logic [8:1] q_next;

  // Per-bit 4:1 mux choosing the next register value for the selected mode.
  // Every branch assigns all 8 bits, so no latch can be inferred.
  always_comb begin
    q_next = q;
    case (select)
      SEL_HOLD:  q_next = q;
      SEL_LEFT:  q_next = {q[7:1], serialin};
      SEL_RIGHT: q_next = {serialin, q[8:2]};
      SEL_LOAD:  q_next = inp;
      default:   q_next = q;
    endcase
  end

  // Register update; synchronous reset overrides the selected mode.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= 8'b0000_0000;
    end else begin
      q <= q_next;
    end
  end

endmodule

// File: tb/tb_universal_shift_register8.sv
// Directed testbench for universal_shift_register8. Inputs change on the
// falling edge, and q is sampled 1 ns after the rising edge.
module tb_universal_shift_register8;

  logic [8:1] inp;
  logic       serialin;
  logic       clk;
  logic       reset;
  logic [8:1] q;
  logic [2:1] select;

  int checks;
  int failures;

  universal_shift_register8 dut (
    .inp      (inp),
    .serialin (serialin),
    .clk      (clk),
    .reset    (reset),
    .q        (q),
    .select   (select)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one set of inputs on the falling edge, then let one rising edge pass.
  task automatic apply(input logic [2:1] sel, input logic [8:1] d,
                       input logic si, input logic rst);
    @(negedge clk);
    select   = sel;
    inp      = d;
    serialin = si;
    reset    = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply(2'b11, 8'hFF, 1'b1, 1'b1);
    checks++;
    if (q !== 8'b0000_0000) begin
      failures++;
      $display("FAIL reset_load: q=%b expected=%b", q, 8'b0000_0000);
    end
    apply(2'b01, 8'hA5, 1'b1, 1'b1);
    checks++;
    if (q !== 8'b0000_0000) begin
      failures++;
      $display("FAIL reset_shift: q=%b expected=%b", q, 8'b0000_0000);
    end
  endtask

  task automatic test_load_hold();
    apply(2'b11, 8'b1011_1001, 1'b0, 1'b0);
    checks++;
    if (q !== 8'b1011_1001) begin
      failures++;
      $display("FAIL load: q=%b expected=%b", q, 8'b1011_1001);
    end
    apply(2'b00, 8'b0100_0110, 1'b1, 1'b0);
    checks++;
    if (q !== 8'b1011_1001) begin
      failures++;
      $display("FAIL hold1: q=%b expected=%b", q, 8'b1011_1001);
    end
    apply(2'b00, 8'b1111_1111, 1'b0, 1'b0);
    checks++;
    if (q !== 8'b1011_1001) begin
      failures++;
      $display("FAIL hold2: q=%b expected=%b", q, 8'b1011_1001);
    end
  endtask

  task automatic test_shift_left();
    logic [8:1] exp_tab [4];
    logic       sin_tab [4];
    exp_tab = '{8'b1110_0000, 8'b1100_0000, 8'b1000_0001, 8'b0000_0011};
    sin_tab = '{1'b0, 1'b0, 1'b1, 1'b1};
    apply(2'b11, 8'b1111_0000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      apply(2'b01, 8'h5A, sin_tab[i], 1'b0);
      checks++;
      if (q !== exp_tab[i]) begin
        failures++;
        $display("FAIL shift_left[%0d]: q=%b expected=%b", i, q, exp_tab[i]);
      end
    end
  endtask

  task automatic test_shift_right();
    logic [8:1] exp_tab [4];
    exp_tab = '{8'b1111_1000, 8'b1111_1100, 8'b1111_1110, 8'b1111_1111};
    apply(2'b11, 8'b1111_0000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      apply(2'b10, 8'h00, 1'b1, 1'b0);
      checks++;
      if (q !== exp_tab[i]) begin
        failures++;
        $display("FAIL shift_right[%0d]: q=%b expected=%b", i, q, exp_tab[i]);
      end
    end
    apply(2'b00, 8'h00, 1'b0, 1'b0);
    checks++;
    if (q !== 8'b1111_1111) begin
      failures++;
      $display("FAIL shift_right_hold: q=%b expected=%b", q, 8'b1111_1111);
    end
  endtask

  task automatic test_flush();
    apply(2'b11, 8'b1010_1010, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      apply(2'b01, 8'hFF, 1'b0, 1'b0);
      if (i == 4) begin
        checks++;
        if (q !== 8'b1010_0000) begin
          failures++;
          $display("FAIL flush_left_mid: q=%b expected=%b", q, 8'b1010_0000);
        end
      end
    end
    checks++;
    if (q !== 8'b0000_0000) begin
      failures++;
      $display("FAIL flush_left: q=%b expected=%b", q, 8'b0000_0000);
    end
    apply(2'b11, 8'b1010_1010, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      apply(2'b10, 8'h00, 1'b1, 1'b0);
      if (i == 4) begin
        checks++;
        if (q !== 8'b1111_1010) begin
          failures++;
          $display("FAIL flush_right_mid: q=%b expected=%b", q, 8'b1111_1010);
        end
      end
    end
    checks++;
    if (q !== 8'b1111_1111) begin
      failures++;
      $display("FAIL flush_right: q=%b expected=%b", q, 8'b1111_1111);
    end
  endtask

  task automatic test_reset_priority();
    apply(2'b11, 8'b0011_0011, 1'b0, 1'b0);
    apply(2'b11, 8'b1111_1111, 1'b0, 1'b1);
    checks++;
    if (q !== 8'b0000_0000) begin
      failures++;
      $display("FAIL reset_prio_load: q=%b expected=%b", q, 8'b0000_0000);
    end
    apply(2'b11, 8'b0101_0101, 1'b0, 1'b0);
    checks++;
    if (q !== 8'b0101_0101) begin
      failures++;
      $display("FAIL reset_release_load: q=%b expected=%b", q, 8'b0101_0101);
    end
    apply(2'b01, 8'h00, 1'b1, 1'b0);
    apply(2'b01, 8'h00, 1'b1, 1'b1);
    checks++;
    if (q !== 8'b0000_0000) begin
      failures++;
      $display("FAIL reset_prio_shift: q=%b expected=%b", q, 8'b0000_0000);
    end
    apply(2'b01, 8'hFF, 1'b1, 1'b0);
    checks++;
    if (q !== 8'b0000_0001) begin
      failures++;
      $display("FAIL reset_release_shift: q=%b expected=%b", q, 8'b0000_0001);
    end
  endtask

  task automatic test_ignored_inputs();
    apply(2'b11, 8'b0011_1100, 1'b1, 1'b0);
    apply(2'b00, 8'hFF, 1'b1, 1'b0);
    checks++;
    if (q !== 8'b0011_1100) begin
      failures++;
      $display("FAIL hold_ignores_serial: q=%b expected=%b", q, 8'b0011_1100);
    end
    apply(2'b01, 8'hFF, 1'b0, 1'b0);
    checks++;
    if (q !== 8'b0111_1000) begin
      failures++;
      $display("FAIL left_ignores_inp: q=%b expected=%b", q, 8'b0111_1000);
    end
    apply(2'b10, 8'hFF, 1'b0, 1'b0);
    checks++;
    if (q !== 8'b0011_1100) begin
      failures++;
      $display("FAIL right_ignores_inp: q=%b expected=%b", q, 8'b0011_1100);
    end
  endtask

  task automatic test_latency();
    apply(2'b11, 8'b1100_0011, 1'b0, 1'b0);
    // Change mode and data just after the edge; q must not follow yet.
    select = 2'b11;
    inp    = 8'b0001_1000;
    #3;
    checks++;
    if (q !== 8'b1100_0011) begin
      failures++;
      $display("FAIL latency_before_edge: q=%b expected=%b", q, 8'b1100_0011);
    end
    @(posedge clk);
    #1;
    checks++;
    if (q !== 8'b0001_1000) begin
      failures++;
      $display("FAIL latency_after_edge: q=%b expected=%b", q, 8'b0001_1000);
    end
    select   = 2'b10;
    serialin = 1'b1;
    #3;
    checks++;
    if (q !== 8'b0001_1000) begin
      failures++;
      $display("FAIL latency_shift_before: q=%b expected=%b", q, 8'b0001_1000);
    end
    @(posedge clk);
    #1;
    checks++;
    if (q !== 8'b1000_1100) begin
      failures++;
      $display("FAIL latency_shift_after: q=%b expected=%b", q, 8'b1000_1100);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    inp      = 8'h00;
    serialin = 1'b0;
    reset    = 1'b1;
    select   = 2'b00;
    test_reset();
    test_load_hold();
    test_shift_left();
    test_shift_right();
    test_flush();
    test_reset_priority();
    test_ignored_inputs();
    test_latency();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
